// File: rtl/conv_pool_frame_ctrl_if.sv
// Start/busy/done handshake, pixel-memory read port and conv-strobe bundle of conv_pool_frame_ctrl.
// master = network sequencer / pixel memory side, slave = the frame controller.
interface conv_pool_frame_ctrl_if #(
    parameter int PP     = 8,
    parameter int ADDR_W = 10
);
    logic                start;
    logic                hold;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd_en;
    logic signed [PP:0]  mem_rdata;
    logic signed [PP:0]  pxl_out;
    logic                pxl_valid;
    logic                conv_win_valid;
    logic                pool_en;

    modport master (
        output start, hold, mem_rdata,
        input  mem_addr, mem_rd_en, pxl_out, pxl_valid, conv_win_valid, pool_en, busy, done
    );

    modport slave (
        input  start, hold, mem_rdata,
        output mem_addr, mem_rd_en, pxl_out, pxl_valid, conv_win_valid, pool_en, busy, done
    );
endinterface

// File: rtl/conv_pool_frame_ctrl.sv
// Frame sequencer for the first CNN layer: raster-reads one frame, streams it to the conv datapath
// and flags fully-inside conv windows and 2x2 pool completions. CONV_CTRL_STALL_CNT_EN adds stall_cnt.
module conv_pool_frame_ctrl #(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int K        = 5,
    parameter int PP       = 8,
    parameter int ADDR_W   = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    conv_pool_frame_ctrl_if.slave bus
`ifdef CONV_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    localparam int CW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TW        = RW + CW;
    localparam int DRAIN_CYC = 2 + PIPE_LAT;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    localparam logic [CW-1:0] WIN_COL  = CW'(K - 1);
    localparam logic [RW-1:0] WIN_ROW  = RW'(K - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               rd_q, rd_d;
    logic [TW-1:0]      tag1_q, tag1_d;
    logic [TW-1:0]      tag2_q, tag2_d;
    logic               pxl_valid_q, pxl_valid_d;
    logic signed [PP:0] pxl_out_q, pxl_out_d;
    logic [PIPE_LAT-1:0] dvld_q, dvld_d;
    logic [TW-1:0]      dtag_q [PIPE_LAT];
    logic [TW-1:0]      dtag_d [PIPE_LAT];
    logic               issue;

    assign issue = (state_q == STREAM) && !bus.hold;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            STREAM: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (col_q == LAST_COL && row_q == LAST_ROW) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DW'(DRAIN_CYC - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The (row,col) tag rides alongside the read: memory stage, output register, then PIPE_LAT conv stages.
    always_comb begin
        rd_d        = issue;
        tag1_d      = {row_q, col_q};
        tag2_d      = tag1_q;
        pxl_valid_d = rd_q;
        pxl_out_d   = rd_q ? bus.mem_rdata : pxl_out_q;
        dvld_d      = dvld_q;
        dtag_d      = dtag_q;
        dvld_d[0]   = pxl_valid_q;
        dtag_d[0]   = tag2_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            dvld_d[i] = dvld_q[i-1];
            dtag_d[i] = dtag_q[i-1];
        end
    end

`ifdef CONV_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && bus.start) begin
            stall_d = '0;
        end else if (state_q == STREAM && bus.hold && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            drain_q     <= '0;
            rd_q        <= 1'b0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            pxl_valid_q <= 1'b0;
            pxl_out_q   <= '0;
            dvld_q      <= '0;
            dtag_q      <= '{default: '0};
`ifdef CONV_CTRL_STALL_CNT_EN
            stall_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            rd_q        <= rd_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            pxl_valid_q <= pxl_valid_d;
            pxl_out_q   <= pxl_out_d;
            dvld_q      <= dvld_d;
            dtag_q      <= dtag_d;
`ifdef CONV_CTRL_STALL_CNT_EN
            stall_q     <= stall_d;
`endif
        end
    end

    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          win;

    // Pool parity is taken relative to the first valid window, so fold in K-1's own parity.
    assign out_row = dtag_q[PIPE_LAT-1][TW-1:CW];
    assign out_col = dtag_q[PIPE_LAT-1][CW-1:0];
    assign win     = dvld_q[PIPE_LAT-1] && (out_row >= WIN_ROW) && (out_col >= WIN_COL);

    assign bus.conv_win_valid = win;
    assign bus.pool_en        = win && (out_row[0] ^ WIN_ROW[0]) && (out_col[0] ^ WIN_COL[0]);
    assign bus.mem_rd_en      = issue;
    assign bus.mem_addr       = addr_q;
    assign bus.pxl_out        = pxl_out_q;
    assign bus.pxl_valid      = pxl_valid_q;
    assign bus.busy           = (state_q == STREAM) || (state_q == DRAIN);
    assign bus.done           = (state_q == DONE);
endmodule

// File: tb/tb_conv_pool_frame_ctrl.sv
// Self-checking bench for conv_pool_frame_ctrl: random frames against a schedule-level reference model.
// Define CONV_CTRL_STALL_CNT_EN to also check stall_cnt.
module tb_conv_pool_frame_ctrl;
    localparam int IMG_W     = 32;
    localparam int IMG_H     = 32;
    localparam int K         = 5;
    localparam int PP        = 8;
    localparam int ADDR_W    = 10;
    localparam int PIPE_LAT  = 2;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int TMAX      = 4096;
    localparam int DRAIN_CYC = 2 + PIPE_LAT;
    localparam int NWIN      = (IMG_H - K + 1) * (IMG_W - K + 1);
    localparam int NPOOL     = ((IMG_H - K + 1) / 2) * ((IMG_W - K + 1) / 2);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    conv_pool_frame_ctrl_if #(.PP(PP), .ADDR_W(ADDR_W)) bus ();

`ifdef CONV_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv_pool_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PP(PP), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef CONV_CTRL_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Pixel memory with one-cycle read latency.
    logic signed [PP:0] mem [NPIX];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    bit                 hold_pat  [TMAX];
    bit                 start_pat [TMAX];
    bit                 e_rd [TMAX];
    bit                 e_pv [TMAX];
    bit                 e_win [TMAX];
    bit                 e_pool [TMAX];
    bit                 e_busy [TMAX];
    int                 e_addr [TMAX];
    logic signed [PP:0] e_pxl [TMAX];
    int                 issue_t [NPIX];
    int                 done_t;
    int                 exp_stall;
    bit                 obs_pv [TMAX];
    int                 obs_done_t, obs_busy_n, win_n, pool_n, first_pool_t, last_pool_t;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // Builds the expected per-cycle schedule from the frame rules: pixel k is issued on the k-th non-held
    // cycle after start, appears on pxl_out two cycles later and on the conv output PIPE_LAT after that.
    task automatic prepFrame(input int holdMode, input int startMode, input bit addrData);
        int k;
        int t;
        int r;
        int c;
        logic [31:0] rnd;
        for (int i = 0; i < TMAX; i++) begin
            hold_pat[i]  = (holdMode == 2 && i < 2500) ? ($urandom_range(5) == 0) : 1'b0;
            start_pat[i] = (startMode == 2) ? 1'b1 : ((startMode == 1) ? ($urandom_range(4) == 0) : 1'b0);
            e_rd[i]   = 1'b0;
            e_pv[i]   = 1'b0;
            e_win[i]  = 1'b0;
            e_pool[i] = 1'b0;
            e_busy[i] = 1'b0;
            e_addr[i] = 0;
            e_pxl[i]  = '0;
            obs_pv[i] = 1'b0;
        end
        start_pat[0] = 1'b1;
        if (holdMode == 1) for (int i = 101; i <= 110; i++) hold_pat[i] = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            rnd    = addrData ? 32'(i) : $urandom;
            mem[i] = rnd[PP:0];
        end
        k = 0;
        for (t = 1; k < NPIX; t++) begin
            if (!hold_pat[t]) begin
                issue_t[k] = t;
                k++;
            end
        end
        done_t    = issue_t[NPIX-1] + DRAIN_CYC + 1;
        exp_stall = 0;
        for (t = 1; t <= issue_t[NPIX-1]; t++) if (hold_pat[t]) exp_stall++;
        for (t = 1; t < done_t; t++) e_busy[t] = 1'b1;
        for (int a = 0; a < NPIX; a++) begin
            r = a / IMG_W;
            c = a % IMG_W;
            e_rd[issue_t[a]]      = 1'b1;
            e_addr[issue_t[a]]    = a;
            e_pv[issue_t[a] + 2]  = 1'b1;
            e_pxl[issue_t[a] + 2] = mem[a];
            if (r >= K - 1 && c >= K - 1) begin
                e_win[issue_t[a] + 2 + PIPE_LAT]  = 1'b1;
                e_pool[issue_t[a] + 2 + PIPE_LAT] = ((r - (K - 1)) % 2 == 1) && ((c - (K - 1)) % 2 == 1);
            end
        end
    endtask

    function automatic logic [63:0] obsVec(input int t);
        logic [ADDR_W-1:0] a;
        logic [PP:0]       p;
        a = e_rd[t] ? bus.mem_addr : {ADDR_W{1'b0}};
        p = e_pv[t] ? bus.pxl_out : {(PP+1){1'b0}};
        return 64'({bus.mem_rd_en, a, bus.pxl_valid, p, bus.conv_win_valid, bus.pool_en, bus.busy, bus.done});
    endfunction

    function automatic logic [63:0] expVec(input int t);
        logic [ADDR_W-1:0] a;
        logic [PP:0]       p;
        logic [31:0]       ai;
        ai = 32'(e_addr[t]);
        a  = ai[ADDR_W-1:0];
        p  = e_pxl[t];
        return 64'({e_rd[t], a, e_pv[t], p, e_win[t], e_pool[t], e_busy[t], (t == done_t)});
    endfunction

    function automatic logic [63:0] allVec();
        return 64'({bus.mem_rd_en, bus.mem_addr, bus.pxl_valid, bus.pxl_out,
                    bus.conv_win_valid, bus.pool_en, bus.busy, bus.done});
    endfunction

    task automatic applyStimulus(input int t);
        bus.start = start_pat[t];
        bus.hold  = hold_pat[t];
    endtask

    task automatic runFrame(input string name, input int abortAddr);
        bit aborted;
        aborted      = 1'b0;
        win_n        = 0;
        pool_n       = 0;
        first_pool_t = -1;
        last_pool_t  = -1;
        obs_done_t   = -1;
        obs_busy_n   = 0;
        for (int t = 0; t <= done_t; t++) begin
            @(posedge clk);
            #1;
            applyStimulus(t);
            @(negedge clk);
            checkOutput($sformatf("%s t=%0d", name, t), obsVec(t), expVec(t));
            obs_pv[t] = bus.pxl_valid;
            if (bus.conv_win_valid) win_n++;
            if (bus.pool_en) begin
                pool_n++;
                if (first_pool_t < 0) first_pool_t = t;
                last_pool_t = t;
            end
            if (bus.busy) obs_busy_n++;
            if (bus.done && obs_done_t < 0) obs_done_t = t;
            if (abortAddr >= 0 && t == issue_t[abortAddr]) begin
                #2 reset = 1'b0;
                #1 checkOutput({name, " async reset"}, allVec(), 64'd0);
`ifdef CONV_CTRL_STALL_CNT_EN
                checkOutput({name, " reset stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            checkOutput({name, " win count"}, 64'(win_n), 64'(NWIN));
            checkOutput({name, " pool count"}, 64'(pool_n), 64'(NPOOL));
            checkOutput({name, " first pool"}, 64'(first_pool_t), 64'(issue_t[K * IMG_W + K] + 2 + PIPE_LAT));
            checkOutput({name, " last pool"}, 64'(last_pool_t), 64'(issue_t[NPIX-1] + 2 + PIPE_LAT));
            checkOutput({name, " done cycle"}, 64'(obs_done_t), 64'(done_t));
`ifdef CONV_CTRL_STALL_CNT_EN
            checkOutput({name, " stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
`endif
        end
    endtask

    task automatic idleCycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.hold  = 1'($urandom_range(1));
            @(negedge clk);
            checkOutput($sformatf("%s idle%0d", name, i),
                        64'({bus.mem_rd_en, bus.pxl_valid, bus.conv_win_valid, bus.pool_en, bus.busy, bus.done}),
                        64'd0);
        end
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset state", allVec(), 64'd0);
`ifdef CONV_CTRL_STALL_CNT_EN
        checkOutput("reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b1;
        idleCycles("post-reset", 2);

        // Clean frame with address-valued pixels: exact cycle numbers are known up front.
        prepFrame(0, 0, 1'b1);
        runFrame("A", -1);
        checkOutput("A done at 1029", 64'(obs_done_t), 64'd1029);
        checkOutput("A busy cycles", 64'(obs_busy_n), 64'd1028);
        idleCycles("A", 3);

        // Ten-cycle hold burst right when address 100 would issue.
        prepFrame(1, 0, 1'b0);
        runFrame("B", -1);
        checkOutput("B done at 1039", 64'(obs_done_t), 64'd1039);
        n = 0;
        for (int t = 101; t <= 110; t++) if (obs_pv[t]) n++;
        checkOutput("B pxl_valid during hold", 64'(n), 64'd2);
`ifdef CONV_CTRL_STALL_CNT_EN
        checkOutput("B stall_cnt 10", 64'(stall_cnt), 64'd10);
`endif
        idleCycles("B", 2);
`ifdef CONV_CTRL_STALL_CNT_EN
        checkOutput("B stall_cnt held", 64'(stall_cnt), 64'd10);
`endif

        // Random holds with stray start pulses, then start held high across back-to-back frames.
        prepFrame(2, 1, 1'b0);
        runFrame("C", -1);
        prepFrame(2, 2, 1'b0);
        runFrame("D", -1);
        prepFrame(0, 2, 1'b0);
        runFrame("E", -1);
        idleCycles("E", 2);

        // Reset mid-frame at address 500, then a full clean frame.
        prepFrame(2, 0, 1'b0);
        runFrame("F", 500);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idleCycles("F", 4);
        prepFrame(0, 0, 1'b1);
        runFrame("G", -1);
        idleCycles("G", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
